// File: rtl/ni_flit_injector.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// ni_flit_injector
// Network-interface injection stage feeding the router's local input port.
// Takes a flit stream from the attached core. For each packet it picks a
// downstream VC by round-robin among the VCs that still hold credit. It writes
// the VC and destination into every flit and registers the flit towards the
// router. Per-VC credit counters track free slots in the router's local VC
// buffers. The router's credit-return pulses replenish them.
//
// Optional feature: define NI_CREDIT_CHECK_EN to build the sticky credit
// overflow/underflow detector. When it is not defined, credit_err is tied to 0.
//
// Ports:
//   clk              in   single clock, all state on rising edge
//   reset            in   synchronous, active-low
//   core_valid       in   core presents a flit
//   core_ready       out  flit accepted this cycle (from state/credits only)
//   core_payload     in   flit payload, PAYLOAD_W bits
//   core_dest        in   destination router, sampled on head flit only
//   core_last        in   tail-flit marker
//   flit_out         out  registered flit {VC, dest, payload} to router
//   flit_valid       out  registered valid to router
//   credit_increment in   one-cycle credit-return pulse per VC
//   busy             out  multi-flit packet in progress
//   credit_err       out  sticky credit overflow/underflow flag
// ---------------------------------------------------------------------------
module ni_flit_injector #(
   parameter  int NUM_VCS         = 4,
   parameter  int NUM_ROUTERS     = 16,
   parameter  int BUF_DEPTH       = 4,
   parameter  int FLIT_DATA_WIDTH = 32,
   localparam int ROUTER_ID_BITS  = $clog2(NUM_ROUTERS),
   localparam int VC_BITS         = $clog2(NUM_VCS),
   localparam int PAYLOAD_W       = FLIT_DATA_WIDTH - VC_BITS - ROUTER_ID_BITS,
   localparam int CRED_W          = $clog2(BUF_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       core_valid,
   output logic                       core_ready,
   input  logic [PAYLOAD_W-1:0]       core_payload,
   input  logic [ROUTER_ID_BITS-1:0]  core_dest,
   input  logic                       core_last,
   output logic [FLIT_DATA_WIDTH-1:0] flit_out,
   output logic                       flit_valid,
   input  logic [NUM_VCS-1:0]         credit_increment,
   output logic                       busy,
   output logic                       credit_err
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                      state_p0, state_nxt;
   logic [CRED_W-1:0]           credit_p0  [NUM_VCS];
   logic [CRED_W-1:0]           credit_nxt [NUM_VCS];
   logic [VC_BITS-1:0]          rr_ptr_p0, rr_ptr_nxt;
   logic [VC_BITS-1:0]          cur_vc_p0, cur_vc_nxt;
   logic [ROUTER_ID_BITS-1:0]   cur_dest_p0, cur_dest_nxt;
   logic [VC_BITS-1:0]          grant_vc, cand_vc, hs_vc;
   logic [ROUTER_ID_BITS-1:0]   hs_dest;
   logic                        grant_ok, hs;
   logic [NUM_VCS-1:0]          dec_vc;
   logic [FLIT_DATA_WIDTH-1:0]  flit_p1;
   logic                        vld_p1;

   // Saturating credit update. Increment and decrement on the same VC cancel.
   // An increment on a full counter is dropped. A decrement on an empty
   // counter is blocked, although ready gating keeps it from happening.
   function automatic logic [CRED_W-1:0] credit_update(
      input logic [CRED_W-1:0] cnt,
      input logic              inc,
      input logic              dec
   );
      logic [CRED_W-1:0] r;
      r = cnt;
      if (inc && !dec) begin
         if (cnt != CRED_W'(BUF_DEPTH)) r = cnt + 1'b1;
      end else if (dec && !inc) begin
         if (cnt != '0) r = cnt - 1'b1;
      end
      return r;
   endfunction

   // Round-robin search: the first VC with credit, starting at rr_ptr and wrapping.
   always_comb begin
      grant_ok = 1'b0;
      grant_vc = rr_ptr_p0;
      cand_vc  = '0;
      for (int i = 0; i < NUM_VCS; i++) begin
         cand_vc = VC_BITS'((int'(rr_ptr_p0) + i) % NUM_VCS);
         if (!grant_ok && (credit_p0[cand_vc] != '0)) begin
            grant_ok = 1'b1;
            grant_vc = cand_vc;
         end
      end
   end

   // In IDLE, ready means some VC holds credit. In SEND, only the held VC counts.
   always_comb begin
      core_ready = 1'b0;
      case (state_p0)
         IDLE:    core_ready = grant_ok;
         SEND:    core_ready = (credit_p0[cur_vc_p0] != '0);
         default: core_ready = 1'b0;
      endcase
   end

   assign hs      = core_valid && core_ready;
   assign hs_vc   = (state_p0 == IDLE) ? grant_vc  : cur_vc_p0;
   assign hs_dest = (state_p0 == IDLE) ? core_dest : cur_dest_p0;
   assign busy    = (state_p0 == SEND);

   always_comb begin
      state_nxt    = state_p0;
      rr_ptr_nxt   = rr_ptr_p0;
      cur_vc_nxt   = cur_vc_p0;
      cur_dest_nxt = cur_dest_p0;
      if (hs) begin
         case (state_p0)
            IDLE: begin
               cur_vc_nxt   = grant_vc;
               cur_dest_nxt = core_dest;
               rr_ptr_nxt   = VC_BITS'((int'(grant_vc) + 1) % NUM_VCS);
               if (!core_last) state_nxt = SEND;
            end
            SEND: begin
               if (core_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      dec_vc = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         dec_vc[v]     = hs && (hs_vc == VC_BITS'(v));
         credit_nxt[v] = credit_update(credit_p0[v], credit_increment[v], dec_vc[v]);
      end
   end

   // ---- stage p0 -> p1: control state update and flit register ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_p0    <= IDLE;
         rr_ptr_p0   <= '0;
         cur_vc_p0   <= '0;
         cur_dest_p0 <= '0;
         for (int v = 0; v < NUM_VCS; v++) credit_p0[v] <= CRED_W'(BUF_DEPTH);
         vld_p1      <= 1'b0;
         flit_p1     <= '0;
      end else begin
         state_p0    <= state_nxt;
         rr_ptr_p0   <= rr_ptr_nxt;
         cur_vc_p0   <= cur_vc_nxt;
         cur_dest_p0 <= cur_dest_nxt;
         for (int v = 0; v < NUM_VCS; v++) credit_p0[v] <= credit_nxt[v];
         vld_p1      <= hs;
         if (hs) flit_p1 <= {hs_vc, hs_dest, core_payload};
      end
   end

   assign flit_out   = flit_p1;
   assign flit_valid = vld_p1;

`ifdef NI_CREDIT_CHECK_EN
   logic credit_err_p1;
   logic err_event;

   // A return pulse on a full VC with no consuming handshake means the
   // router gave back a credit it never owed.
   always_comb begin
      err_event = hs && (credit_p0[hs_vc] == '0);
      for (int v = 0; v < NUM_VCS; v++) begin
         if (credit_increment[v] && !dec_vc[v] && (credit_p0[v] == CRED_W'(BUF_DEPTH)))
            err_event = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)         credit_err_p1 <= 1'b0;
      else if (err_event) credit_err_p1 <= 1'b1;
   end

   assign credit_err = credit_err_p1;
`else
   assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_ni_flit_injector.sv
`timescale 1ns/1ps
// Directed bench for ni_flit_injector (NUM_VCS=4, NUM_ROUTERS=16,
// BUF_DEPTH=4, FLIT_DATA_WIDTH=32, so PAYLOAD_W=26).
module tb_ni_flit_injector;

   localparam int PW = 26;

   logic          clk;
   logic          reset;
   logic          core_valid;
   logic          core_ready;
   logic [PW-1:0] core_payload;
   logic [3:0]    core_dest;
   logic          core_last;
   logic [31:0]   flit_out;
   logic          flit_valid;
   logic [3:0]    credit_increment;
   logic          busy;
   logic          credit_err;

   int            tests;
   int            fails;
   logic [31:0]   sb[$];
   logic [31:0]   last_exp;
   logic [PW-1:0] pay;
   logic          exp_err;

   ni_flit_injector #(
      .NUM_VCS(4), .NUM_ROUTERS(16), .BUF_DEPTH(4), .FLIT_DATA_WIDTH(32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .core_valid       (core_valid),
      .core_ready       (core_ready),
      .core_payload     (core_payload),
      .core_dest        (core_dest),
      .core_last        (core_last),
      .flit_out         (flit_out),
      .flit_valid       (flit_valid),
      .credit_increment (credit_increment),
      .busy             (busy),
      .credit_err       (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Hold reset for two edges and check the reset values of every output.
   task automatic do_reset();
      core_valid       = 1'b0;
      core_last        = 1'b0;
      credit_increment = '0;
      reset            = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_flit_valid", {31'd0, flit_valid}, 32'd0);
      chk("rst_flit_out",   flit_out,            32'd0);
      chk("rst_busy",       {31'd0, busy},       32'd0);
      chk("rst_credit_err", {31'd0, credit_err}, 32'd0);
      chk("rst_core_ready", {31'd0, core_ready}, 32'd1);
      exp_err  = 1'b0;
      last_exp = '0;
      reset    = 1'b1;
   endtask

   // One clock cycle. Drive the inputs, check ready, and push the expected
   // flit on a handshake. After the edge, check the flit, busy and credit_err.
   task automatic cyc(input logic v, input logic [3:0] d, input logic l, input logic [3:0] inc,
                      input logic er, input logic [1:0] ev, input logic [3:0] ed, input logic eb);
      logic        exp_hs;
      logic [31:0] e;
      core_valid       = v;
      core_payload     = pay;
      core_dest        = d;
      core_last        = l;
      credit_increment = inc;
      #1;
      chk("core_ready", {31'd0, core_ready}, {31'd0, er});
      exp_hs = v && er;
      if (exp_hs) sb.push_back({ev, ed, pay});
      pay = pay + 1'b1;
      @(posedge clk);
      #1;
      core_valid       = 1'b0;
      credit_increment = '0;
      if (exp_hs) begin
         e = sb.pop_front();
         chk("flit_valid_hs", {31'd0, flit_valid}, 32'd1);
         chk("flit_out",      flit_out,            e);
         last_exp = e;
      end else begin
         chk("flit_valid_idle", {31'd0, flit_valid}, 32'd0);
         chk("flit_out_hold",   flit_out,            last_exp);
      end
      chk("busy",       {31'd0, busy},       {31'd0, eb});
      chk("credit_err", {31'd0, credit_err}, {31'd0, exp_err});
   endtask

   initial begin
      tests            = 0;
      fails            = 0;
      exp_err          = 1'b0;
      last_exp         = '0;
      core_payload     = '0;
      core_dest        = '0;
      core_last        = 1'b0;
      core_valid       = 1'b0;
      credit_increment = '0;
      reset            = 1'b0;

      // Single-flit packet to dest 5, payload 0x2A, on VC0.
      do_reset();
      pay = 26'h2A;
      cyc(1, 4'd5, 1, 4'b0000, 1, 2'd0, 4'd5, 0);
      cyc(0, 4'd0, 0, 4'b0000, 1, 2'd0, 4'd0, 0);

      // Three-flit packet to dest 9. The body flits present dest 2, which is ignored.
      do_reset();
      cyc(1, 4'd9, 0, 4'b0000, 1, 2'd0, 4'd9, 1);
      cyc(1, 4'd2, 0, 4'b0000, 1, 2'd0, 4'd9, 1);
      cyc(1, 4'd2, 1, 4'b0000, 1, 2'd0, 4'd9, 0);

      // Six-flit packet. The credits run out after 4 flits, and each return releases one flit.
      do_reset();
      cyc(1, 4'd11, 0, 4'b0000, 1, 2'd0, 4'd11, 1);
      for (int i = 0; i < 3; i++) cyc(1, 4'd11, 0, 4'b0000, 1, 2'd0, 4'd11, 1);
      cyc(1, 4'd11, 0, 4'b0001, 0, 2'd0, 4'd0,  1);
      cyc(1, 4'd11, 0, 4'b0000, 1, 2'd0, 4'd11, 1);
      cyc(1, 4'd11, 1, 4'b0000, 0, 2'd0, 4'd0,  1);
      cyc(1, 4'd11, 1, 4'b0001, 0, 2'd0, 4'd0,  1);
      cyc(1, 4'd11, 1, 4'b0000, 1, 2'd0, 4'd11, 0);

      // VC0 is empty and rr_ptr=1. Drain VC1 and VC2, then VC3.
      for (int i = 0; i < 3; i++) cyc(1, 4'd3, 0, 4'b0000, 1, 2'd1, 4'd3, 1);
      cyc(1, 4'd3, 1, 4'b0000, 1, 2'd1, 4'd3, 0);
      for (int i = 0; i < 3; i++) cyc(1, 4'd4, 0, 4'b0000, 1, 2'd2, 4'd4, 1);
      cyc(1, 4'd4, 1, 4'b0000, 1, 2'd2, 4'd4, 0);
      cyc(1, 4'd6,  1, 4'b0000, 1, 2'd3, 4'd6,  0);
      cyc(1, 4'd7,  1, 4'b0000, 1, 2'd3, 4'd7,  0);
      cyc(1, 4'd12, 1, 4'b0000, 1, 2'd3, 4'd12, 0);
      cyc(1, 4'd12, 1, 4'b0000, 1, 2'd3, 4'd12, 0);
      // All VCs are empty. Return VC1, then VC0: the search from rr_ptr=2 wraps to VC0.
      cyc(1, 4'd8,  1, 4'b0010, 0, 2'd0, 4'd0,  0);
      cyc(1, 4'd8,  1, 4'b0000, 1, 2'd1, 4'd8,  0);
      cyc(1, 4'd10, 1, 4'b0001, 0, 2'd0, 4'd0,  0);
      cyc(1, 4'd10, 1, 4'b0000, 1, 2'd0, 4'd10, 0);

      // A handshake on VC1 in the same cycle as a VC1 return leaves the count at 4.
      do_reset();
      cyc(1, 4'd1,  1, 4'b0000, 1, 2'd0, 4'd1,  0);
      cyc(1, 4'd13, 0, 4'b0010, 1, 2'd1, 4'd13, 1);
      for (int i = 0; i < 4; i++) cyc(1, 4'd2, 0, 4'b0000, 1, 2'd1, 4'd13, 1);
      cyc(1, 4'd2, 1, 4'b0000, 0, 2'd0, 4'd0,  1);
      cyc(1, 4'd2, 1, 4'b0010, 0, 2'd0, 4'd0,  1);
      cyc(1, 4'd2, 1, 4'b0000, 1, 2'd1, 4'd13, 0);

      // A return on VC2 at full credit saturates the count and flags the error when checking is built.
      do_reset();
`ifdef NI_CREDIT_CHECK_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      cyc(0, 4'd0, 0, 4'b0100, 1, 2'd0, 4'd0, 0);
      cyc(0, 4'd0, 0, 4'b0000, 1, 2'd0, 4'd0, 0);
      cyc(1, 4'd1, 1, 4'b0000, 1, 2'd0, 4'd1, 0);
      cyc(1, 4'd2, 1, 4'b0000, 1, 2'd1, 4'd2, 0);
      cyc(1, 4'd14, 0, 4'b0000, 1, 2'd2, 4'd14, 1);
      for (int i = 0; i < 3; i++) cyc(1, 4'd14, 0, 4'b0000, 1, 2'd2, 4'd14, 1);
      cyc(1, 4'd14, 0, 4'b0000, 0, 2'd0, 4'd0, 1);

      // Reset in the middle of that packet. Afterwards a fresh head goes to VC0 with 4 credits.
      do_reset();
      cyc(1, 4'd15, 0, 4'b0000, 1, 2'd0, 4'd15, 1);
      for (int i = 0; i < 3; i++) cyc(1, 4'd3, 0, 4'b0000, 1, 2'd0, 4'd15, 1);
      cyc(1, 4'd3, 1, 4'b0000, 0, 2'd0, 4'd0,  1);
      cyc(1, 4'd3, 1, 4'b0001, 0, 2'd0, 4'd0,  1);
      cyc(1, 4'd3, 1, 4'b0000, 1, 2'd0, 4'd15, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ni_flit_injector.md
# ni_flit_injector

Network-interface injection stage sitting directly upstream of `router_top`'s local input port (port 0). Accepts a flit stream from the attached core, allocates a downstream VC per packet by round-robin among VCs holding credits, stamps VC and destination into each flit header, and drives `input_data[0]`/`input_valid[0]`. Per-VC credit counters mirror the router's local VC buffer occupancy and are replenished by the router's local-port credit-return pulses.

## Interface
- `NUM_VCS`, 4, VCs on the router local input port
- `NUM_ROUTERS`, 16, routers in the mesh; `ROUTER_ID_BITS = $clog2(NUM_ROUTERS)`
- `BUF_DEPTH`, 4, flit slots per router VC buffer; initial and maximum credit per VC
- Derived: `VC_BITS = $clog2(NUM_VCS)`, `PAYLOAD_W = FLIT_DATA_WIDTH - VC_BITS - ROUTER_ID_BITS`, `CRED_W = $clog2(BUF_DEPTH+1)`

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  synchronous, active-low
- `core_valid`  in  1  core presents a flit
- `core_ready`  out  1  injector accepts the flit this cycle
- `core_payload`  in  PAYLOAD_W  flit payload
- `core_dest`  in  ROUTER_ID_BITS  destination router; sampled on head flit only
- `core_last`  in  1  tail-flit marker
- `flit_out`  out  FLIT_DATA_WIDTH  to router `input_data[0]`
- `flit_valid`  out  1  to router `input_valid[0]`
- `credit_increment`  in  NUM_VCS  one-cycle credit-return pulse per VC from the router
- `busy`  out  1  packet in progress (state SEND)
- `credit_err`  out  1  sticky credit overflow/underflow flag

## Operation
- Flit format (from `VR_define.vh`): `[FLIT_DATA_WIDTH-1 -: VC_BITS]` = VC, next `ROUTER_ID_BITS` = destination, low `PAYLOAD_W` = payload.
- State IDLE: `core_ready = |(credit[v] != 0)` over all v. On handshake: grant the first VC with nonzero credit searching from `rr_ptr` upward with wrap; latch `cur_vc` and `cur_dest = core_dest`; emit head flit; `rr_ptr <= grant+1 mod NUM_VCS`. If `core_last`, stay IDLE (single-flit packet); else go to SEND.
- State SEND: `core_ready = (credit[cur_vc] != 0)`; `core_dest` ignored, `cur_dest` used. On handshake with `core_last`, go to IDLE.
- Every handshake decrements `credit[cur_vc]` (granted VC for a head flit). `credit_increment[v]` increments `credit[v]`. Simultaneous decrement and increment on the same VC leaves the count unchanged.
- A VC is held for the whole packet; no interleaving between packets.
- Increment at `credit == BUF_DEPTH` saturates (count held). Decrement at zero cannot occur, since ready is gated.
- Reset mid-packet: state returns to IDLE, credits return to `BUF_DEPTH`, and any partial packet is abandoned. The core restarts from a head flit.

## Timing
- Reset values: `flit_out = 0`, `flit_valid = 0`, `busy = 0`, `credit_err = 0`, all credits `= BUF_DEPTH`, `rr_ptr = 0`, state IDLE. `core_ready` is combinational and equals 1 immediately after reset.
- `core_ready` is combinational from state and credits only. It never depends on `core_valid`.
- Latency: a flit accepted in cycle N appears on `flit_out` with `flit_valid = 1` in cycle N+1 (registered).
- `flit_valid` is 0 in any cycle following a non-handshake cycle; `flit_out` holds its last value.
- Credit counts update on the edge ending the handshake or pulse cycle. A credit returned in cycle N can enable `core_ready` in cycle N+1.
- Throughput: 1 flit/cycle while credits last.

## Configuration
- `NI_CREDIT_CHECK_EN` defined:
  - `credit_err` sets (sticky until reset) on any `credit_increment[v]` arriving with `credit[v] == BUF_DEPTH` and no same-cycle decrement on v.
  - `credit_err` also sets on a handshake with zero credit (defensive check).
- Not defined: `credit_err` is tied to 0 and the checking logic is absent. Saturation behaviour is identical in both builds.

## Test plan
- Reset, then one single-flit packet, `core_dest = 5`, payload `0x2A` → next cycle `flit_valid = 1`, VC field 0, dest field 5, payload `0x2A`; `credit[0] = 3`; `rr_ptr = 1`; `busy` stays 0.
- 3-flit packet to dest 9, `core_dest` changed to 2 on body flits → all three flits carry VC 0 and dest 9 on consecutive cycles; `busy = 1` after the head, 0 after the tail.
- 6-flit packet with no credit returns → 4 flits accepted, `core_ready = 0` for flit 5. Pulse `credit_increment[0]` for one cycle → flit 5 accepted the next cycle, then stall again.
- Drain VC0–VC2 to zero credit with `rr_ptr = 1`, then start a new head flit → grant VC3. Next head flit with only VC0 replenished → grant VC0 (wrap).
- Same-cycle handshake on VC1 plus `credit_increment[1]` → `credit[1]` unchanged.
- With `NI_CREDIT_CHECK_EN`: `credit_increment[2]` at full credit → `credit_err = 1` and it stays 1. Assert `reset = 0` mid-packet → all outputs return to reset values and credits return to 4.
